adder_ring_measure_ctrl: RTL

Measurement sequencer for the instrumented Sklansky adder inside its Caravel wrapper. On each request it loads the A/B operands, waits a settle window, captures the static sum, then enables the ring-oscillator path through one selected adder bit. It counts `chain_out` rising edges over a programmable gate window and reports the count with a done pulse. It replaces direct LA-bit poking of `a_input`/`b_input`/ring-enable with a single start/done handshake.

---
 rtl/adder_ring_measure_pkg.sv | 19 +
 rtl/chain_edge_sync.sv | 35 +++
 rtl/adder_ring_measure_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/adder_ring_measure_pkg.sv
// Shared types and default widths for the adder ring-oscillator measurement sequencer.
package adder_ring_measure_pkg;

  localparam int DEFAULT_WIDTH  = 32;
  localparam int DEFAULT_SEL_W  = $clog2(DEFAULT_WIDTH);
  localparam int DEFAULT_CNT_W  = 32;
  localparam int DEFAULT_GATE_W = 16;
  localparam int DEFAULT_SET_W  = 8;

  // Sequencer phases: operand load, static settle, gated ring count, result publish.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_MEASURE,
    ST_CAPTURE
  } state_t;

endpackage : adder_ring_measure_pkg

// File: rtl/chain_edge_sync.sv
// Brings the free-running ring output into the wb_clk_i domain and flags rising edges.
// The previous-sample flop only follows the synchronizer while armed or tracking, so a
// level that is already high when counting begins never reads as an edge.
module chain_edge_sync (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  input  logic chain_out,
  input  logic arm,
  input  logic track,
  output logic rise
);

  logic sync1;
  logic sync2;
  logic prev;

  // Two-flop synchronizer plus the previous-sample flop used for edge detection.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let sync2 take the old sync1, forming a real two-stage chain.
      sync1 <= chain_out;
      sync2 <= sync1;
      if (arm || track) begin
        prev <= sync2;
      end
    end
  end

  assign rise = track & sync2 & ~prev;

endmodule : chain_edge_sync

// File: rtl/adder_ring_measure_ctrl.sv
// Measurement sequencer for the instrumented Sklansky adder: loads operands, waits a
// settle window, captures the static sum, then counts ring-oscillator edges through one
// selected adder bit over a gate window and reports the count with a one-cycle done.
module adder_ring_measure_ctrl
  import adder_ring_measure_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int SEL_W  = DEFAULT_SEL_W,
  parameter int CNT_W  = DEFAULT_CNT_W,
  parameter int GATE_W = DEFAULT_GATE_W,
  parameter int SET_W  = DEFAULT_SET_W
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              active,
  input  logic              start,
  input  logic [WIDTH-1:0]  a_operand,
  input  logic [WIDTH-1:0]  b_operand,
  input  logic [SEL_W-1:0]  ring_bit_sel,
  input  logic [SET_W-1:0]  settle_cycles,
  input  logic [GATE_W-1:0] gate_cycles,
  input  logic              chain_out,
  input  logic [WIDTH-1:0]  sum_in,
  output logic [WIDTH-1:0]  a_input,
  output logic [WIDTH-1:0]  b_input,
  output logic [WIDTH-1:0]  ring_en_onehot,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  sum_capture,
  output logic [CNT_W-1:0]  edge_count,
  output logic              overflow
);

  // One down-counter serves both the settle and the gate window.
  localparam int WIN_W = (GATE_W > SET_W) ? GATE_W : SET_W;

  state_t             state;
  logic [SEL_W-1:0]   sel_q;
  logic [GATE_W-1:0]  gate_q;
  logic [WIN_W-1:0]   win_cnt;
  logic [CNT_W-1:0]   edge_cnt;
  logic               ovf_q;
  logic               last_win;
  logic               arm;
  logic               track;
  logic               rise;

  assign last_win = (win_cnt == WIN_W'(1));
  // Re-seed the edge detector on the final settle cycle so MEASURE starts from the current level.
  assign arm      = (state == ST_SETTLE) && last_win && (gate_q != '0);
  assign track    = (state == ST_MEASURE);

  chain_edge_sync u_chain_edge_sync (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .chain_out (chain_out),
    .arm       (arm),
    .track     (track),
    .rise      (rise)
  );

  // Sequencer FSM with window counter, saturating edge counter and registered results.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state          <= ST_IDLE;
      sel_q          <= '0;
      gate_q         <= '0;
      win_cnt        <= '0;
      edge_cnt       <= '0;
      ovf_q          <= 1'b0;
      a_input        <= '0;
      b_input        <= '0;
      ring_en_onehot <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      sum_capture    <= '0;
      edge_count     <= '0;
      overflow       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state != ST_IDLE && !active) begin
        // Abort: drop the ring, leave operands and last results untouched, no done.
        state          <= ST_IDLE;
        busy           <= 1'b0;
        ring_en_onehot <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start && active) begin
              state <= ST_LOAD;
              busy  <= 1'b1;
            end
          end
          ST_LOAD: begin
            a_input  <= a_operand;
            b_input  <= b_operand;
            sel_q    <= ring_bit_sel;
            gate_q   <= gate_cycles;
            win_cnt  <= (settle_cycles == '0) ? WIN_W'(1) : WIN_W'(settle_cycles);
            edge_cnt <= '0;
            ovf_q    <= 1'b0;
            state    <= ST_SETTLE;
          end
          ST_SETTLE: begin
            if (last_win) begin
              sum_capture <= sum_in;
              if (gate_q == '0) begin
                state <= ST_CAPTURE;
              end else begin
                state          <= ST_MEASURE;
                win_cnt        <= WIN_W'(gate_q);
                ring_en_onehot <= WIDTH'(1) << sel_q;
              end
            end else begin
              win_cnt <= win_cnt - WIN_W'(1);
            end
          end
          ST_MEASURE: begin
            if (rise) begin
              if (&edge_cnt) begin
                ovf_q <= 1'b1;
              end else begin
                edge_cnt <= edge_cnt + CNT_W'(1);
              end
            end
            if (last_win) begin
              state          <= ST_CAPTURE;
              ring_en_onehot <= '0;
            end else begin
              win_cnt <= win_cnt - WIN_W'(1);
            end
          end
          ST_CAPTURE: begin
            edge_count <= edge_cnt;
            overflow   <= ovf_q;
            done       <= 1'b1;
            busy       <= 1'b0;
            state      <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule : adder_ring_measure_ctrl
